// File: rtl/ring_pkg.sv
// Shared types and constants for the animated ring sequencer and its pixel pipeline.
package ring_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GROW   = 2'd1,
    ST_HOLD   = 2'd2,
    ST_SHRINK = 2'd3
  } ring_state_t;

  localparam int OLED_W      = 96;
  localparam int OLED_H      = 64;
  localparam int OLED_PIXELS = OLED_W * OLED_H;

  // Entry 0 sits in the low bits so PALETTE[0] is the first colour shown.
  localparam logic [3:0][15:0] PALETTE = {16'h001F, 16'h07E0, 16'hF800, 16'hFC00};

  function automatic logic [11:0] sq6(input logic [5:0] v);
    return 12'({6'd0, v} * {6'd0, v});
  endfunction

endpackage

// File: rtl/ring_pixel_pipe.sv
// Two-stage ring renderer: stage 1 registers the pixel offset from the centre,
// stage 2 tests the squared distance against the current radius band.
module ring_pixel_pipe
  import ring_pkg::*;
#(
  parameter int CX    = 48,
  parameter int CY    = 32,
  parameter int THICK = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [12:0] i_pixel_index,
  input  logic [5:0]  i_r_in,
  input  logic        i_enable,
  input  logic [15:0] i_color,
  output logic [15:0] o_color
);

  logic [6:0]         w_row;
  logic [6:0]         w_col;
  logic signed [7:0]  w_dx;
  logic signed [7:0]  w_dy;
  logic signed [7:0]  r_dx;
  logic signed [7:0]  r_dy;
  logic signed [15:0] w_dx_ext;
  logic signed [15:0] w_dy_ext;
  logic [15:0]        w_dx_sq;
  logic [15:0]        w_dy_sq;
  logic [11:0]        w_d2;
  logic [5:0]         w_r_out;
  logic [11:0]        w_lo;
  logic [11:0]        w_hi;
  logic [15:0]        r_color;

  assign w_row = 7'(i_pixel_index / 13'(OLED_W));
  assign w_col = 7'(i_pixel_index % 13'(OLED_W));
  assign w_dx  = {1'b0, w_col} - 8'(CX);
  assign w_dy  = {1'b0, w_row} - 8'(CY);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_dx <= '0;
      r_dy <= '0;
    end else begin
      r_dx <= w_dx;
      r_dy <= w_dy;
    end
  end

  // Radius and enable are sampled live here so a new frame renders with its new radius.
  assign w_dx_ext = 16'(r_dx);
  assign w_dy_ext = 16'(r_dy);
  assign w_dx_sq  = 16'(w_dx_ext * w_dx_ext);
  assign w_dy_sq  = 16'(w_dy_ext * w_dy_ext);
  assign w_d2     = 12'(w_dx_sq + w_dy_sq);
  assign w_r_out  = i_r_in + 6'(THICK);
  assign w_lo     = sq6(i_r_in);
  assign w_hi     = sq6(w_r_out);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_color <= '0;
    end else begin
      r_color <= (i_enable && (w_d2 >= w_lo) && (w_d2 <= w_hi)) ? i_color : 16'h0000;
    end
  end

  assign o_color = r_color;

endmodule

// File: rtl/ring_sequencer.sv
// Animated-ring controller: grow/hold/shrink radius sequencing committed at frame ticks.
// Define RING_CYCLE_COLOR_EN to cycle the ring colour through a 4-entry palette.
module ring_sequencer
  import ring_pkg::*;
#(
  parameter int          CX          = 48,
  parameter int          CY          = 32,
  parameter int          R_MIN       = 4,
  parameter int          R_MAX       = 28,
  parameter int          THICK       = 2,
  parameter int          HOLD_FRAMES = 30,
  parameter logic [15:0] COLOR       = 16'hFC00
) (
  input  logic        clk25,
  input  logic        reset,
  input  logic [12:0] pixel_index,
  input  logic        start,
  input  logic        stop,
  output logic [15:0] color,
  output logic        busy,
  output logic        frame_done
);

  localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

  ring_state_t   r_state;
  ring_state_t   w_state_next;
  logic [5:0]    r_in;
  logic [5:0]    w_in_next;
  logic [HW-1:0] r_hold_cnt;
  logic [HW-1:0] w_hold_cnt_next;
  logic          r_start_pend;
  logic          w_start_pend_next;
  logic          r_stop_pend;
  logic          w_stop_pend_next;
  logic [12:0]   r_prev_index;
  logic          r_frame_done;
  logic          w_tick;
  logic          w_enable;
  logic [15:0]   w_active_color;

  // prev index resets to 0, so index 0 held through reset does not tick.
  assign w_tick   = (pixel_index == 13'd0) && (r_prev_index != 13'd0);
  assign w_enable = (r_state != ST_IDLE);

  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_in         <= 6'(R_MIN);
      r_hold_cnt   <= '0;
      r_start_pend <= 1'b0;
      r_stop_pend  <= 1'b0;
      r_prev_index <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_in         <= w_in_next;
      r_hold_cnt   <= w_hold_cnt_next;
      r_start_pend <= w_start_pend_next;
      r_stop_pend  <= w_stop_pend_next;
      r_prev_index <= pixel_index;
      r_frame_done <= w_tick && (r_state != ST_IDLE);
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_in_next         = r_in;
    w_hold_cnt_next   = r_hold_cnt;
    w_start_pend_next = r_start_pend;
    w_stop_pend_next  = r_stop_pend;
    case (r_state)
      ST_IDLE: begin
        w_start_pend_next = r_start_pend | start;
        if (w_tick && r_start_pend) begin
          w_state_next      = ST_GROW;
          w_in_next         = 6'(R_MIN);
          w_start_pend_next = 1'b0;
        end
      end
      ST_GROW: begin
        w_stop_pend_next = r_stop_pend | stop;
        if (w_tick) begin
          if (r_in == 6'(R_MAX)) begin
            w_state_next    = ST_HOLD;
            w_hold_cnt_next = '0;
          end else begin
            w_in_next = r_in + 6'd1;
          end
        end
      end
      ST_HOLD: begin
        w_stop_pend_next = r_stop_pend | stop;
        if (w_tick) begin
          if (r_hold_cnt == HW'(HOLD_FRAMES - 1)) begin
            w_state_next = ST_SHRINK;
          end else begin
            w_hold_cnt_next = r_hold_cnt + 1'b1;
          end
        end
      end
      ST_SHRINK: begin
        w_stop_pend_next = r_stop_pend | stop;
        if (w_tick) begin
          if (r_in == 6'(R_MIN)) begin
            if (r_stop_pend) begin
              w_state_next     = ST_IDLE;
              w_stop_pend_next = 1'b0;
            end else begin
              w_state_next = ST_GROW;
            end
          end else begin
            w_in_next = r_in - 6'd1;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

`ifdef RING_CYCLE_COLOR_EN
  logic [1:0] r_pal_idx;
  logic       w_cycle_end;

  assign w_cycle_end = w_tick && (r_state == ST_SHRINK) && (r_in == 6'(R_MIN));

  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      r_pal_idx <= 2'd0;
    end else if (w_cycle_end) begin
      r_pal_idx <= r_pal_idx + 2'd1;
    end
  end

  assign w_active_color = PALETTE[r_pal_idx];
`else
  assign w_active_color = COLOR;
`endif

  ring_pixel_pipe #(
    .CX    (CX),
    .CY    (CY),
    .THICK (THICK)
  ) u_pipe (
    .i_clk         (clk25),
    .i_rst         (reset),
    .i_pixel_index (pixel_index),
    .i_r_in        (r_in),
    .i_enable      (w_enable),
    .i_color       (w_active_color),
    .o_color       (color)
  );

  assign busy       = (r_state != ST_IDLE) | r_start_pend;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_ring_sequencer.sv
// Scoreboard bench for ring_sequencer: a frame-level reference model predicts every
// pixel colour, busy and frame_done; colours are queued and popped two cycles later.
`timescale 1ns/1ps
module tb_ring_sequencer;

  localparam int CX = 48, CY = 32, R_MIN = 4, R_MAX = 6, THICK = 2, HOLD_FRAMES = 2;
  localparam int M_IDLE = 0, M_GROW = 1, M_HOLD = 2, M_SHRINK = 3;

  logic        clk25 = 1'b0;
  logic        reset;
  logic [12:0] pixel_index;
  logic        start;
  logic        stop;
  logic [15:0] color;
  logic        busy;
  logic        frame_done;

  always #5 clk25 = ~clk25;

  ring_sequencer #(
    .CX(CX), .CY(CY), .R_MIN(R_MIN), .R_MAX(R_MAX), .THICK(THICK),
    .HOLD_FRAMES(HOLD_FRAMES), .COLOR(16'hFC00)
  ) dut (
    .clk25(clk25), .reset(reset), .pixel_index(pixel_index), .start(start),
    .stop(stop), .color(color), .busy(busy), .frame_done(frame_done)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_q[$];
  int          frame_pix[$];
  int          pos = 0;
  int          fl;
  int          m_state, m_r, m_hold, m_prev, m_pal, m_exits, m_frames;
  bit          m_start_pend, m_stop_pend;
  bit          pulse_start, pulse_stop;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h (frame %0d)", tag, got, exp, m_frames);
    end
  endtask

  function automatic logic [15:0] active_color();
`ifdef RING_CYCLE_COLOR_EN
    case (m_pal)
      0:       return 16'hFC00;
      1:       return 16'hF800;
      2:       return 16'h07E0;
      default: return 16'h001F;
    endcase
`else
    return 16'hFC00;
`endif
  endfunction

  function automatic logic [15:0] model_color(input int idx);
    int dx, dy, d2, ro;
    if (m_state == M_IDLE) return 16'h0000;
    dx = (idx % 96) - CX;
    dy = (idx / 96) - CY;
    d2 = dx * dx + dy * dy;
    ro = m_r + THICK;
    if (d2 >= m_r * m_r && d2 <= ro * ro) return active_color();
    return 16'h0000;
  endfunction

  task automatic model_reset();
    m_state = M_IDLE; m_r = R_MIN; m_hold = 0; m_pal = 0; m_prev = 0;
    m_start_pend = 0; m_stop_pend = 0;
    exp_q.delete();
    exp_q.push_back(16'h0000);
  endtask

  task automatic model_update(input bit tick, input bit st, input bit sp);
    bit old_stop;
    old_stop = m_stop_pend;
    if (m_state != M_IDLE && sp) m_stop_pend = 1;
    case (m_state)
      M_IDLE: begin
        if (tick && m_start_pend) begin
          m_state = M_GROW; m_r = R_MIN; m_start_pend = 0;
        end else if (st) begin
          m_start_pend = 1;
        end
      end
      M_GROW: if (tick) begin
        if (m_r == R_MAX) begin m_state = M_HOLD; m_hold = 0; end
        else m_r++;
      end
      M_HOLD: if (tick) begin
        if (m_hold == HOLD_FRAMES - 1) m_state = M_SHRINK;
        else m_hold++;
      end
      default: if (tick) begin
        if (m_r == R_MIN) begin
          m_exits++;
          m_pal = (m_pal + 1) % 4;
          if (old_stop) begin m_state = M_IDLE; m_stop_pend = 0; end
          else m_state = M_GROW;
        end else begin
          m_r--;
        end
      end
    endcase
  endtask

  task automatic step();
    int idx;
    bit tick, st, sp, exp_fd, exp_busy;
    idx = frame_pix[pos];
    pos = (pos + 1) % fl;
    st = pulse_start; sp = pulse_stop;
    pulse_start = 0; pulse_stop = 0;
    pixel_index = 13'(idx);
    start = st;
    stop  = sp;
    tick   = (idx == 0) && (m_prev != 0);
    m_prev = idx;
    exp_fd = tick && (m_state != M_IDLE);
    model_update(tick, st, sp);
    exp_q.push_back(model_color(idx));
    exp_busy = (m_state != M_IDLE) || m_start_pend;
    @(posedge clk25); #1;
    check_eq("frame_done", 16'(frame_done), 16'(exp_fd));
    check_eq("busy", 16'(busy), 16'(exp_busy));
    check_eq("color", color, exp_q.pop_front());
    if (tick) begin
      m_frames++;
      $display("frame %0d: state %0d r_in %0d palette %0d checks %0d", m_frames, m_state, m_r, m_pal, n_checks);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int e;
    frame_pix.push_back(0);
    for (int i = 3100; i <= 3163; i++) frame_pix.push_back(i);
    for (int i = 3496; i <= 3512; i++) frame_pix.push_back(i);
    frame_pix.push_back(6143);
    fl = frame_pix.size();

    reset = 1'b1; pixel_index = '0; start = 1'b0; stop = 1'b0;
    pulse_start = 0; pulse_stop = 0; m_exits = 0; m_frames = 0;
    model_reset();
    #2;
    check_eq("rst_color", color, 16'h0000);
    check_eq("rst_busy", 16'(busy), 16'h0000);
    check_eq("rst_frame_done", 16'(frame_done), 16'h0000);
    repeat (2) @(posedge clk25);
    #1 reset = 1'b0;

    // Start, then run ten frame ticks through one full cycle.
    run(5);
    pulse_start = 1;
    run(fl * 10);

    // Stop requested in GROW: finish the cycle, drop to IDLE, then one blank frame.
    pulse_stop = 1;
    for (int i = 0; i < fl * 12 && m_state != M_IDLE; i++) step();
    run(fl);

    // Simultaneous start and stop in IDLE: start wins, cycle repeats into the next HOLD.
    run(5);
    pulse_start = 1;
    pulse_stop  = 1;
    e = m_exits;
    for (int i = 0; i < fl * 20 && !(m_exits > e && m_state == M_HOLD && pos == 29); i++) step();
    check_eq("reached_hold", 16'(m_state), 16'(M_HOLD));

    // Asynchronous reset mid-frame in HOLD, right after a ring pixel reached the output.
    #2 reset = 1'b1;
    #1;
    check_eq("arst_color", color, 16'h0000);
    check_eq("arst_busy", 16'(busy), 16'h0000);
    check_eq("arst_frame_done", 16'(frame_done), 16'h0000);
    repeat (3) begin
      @(posedge clk25); #1;
      check_eq("hold_rst_color", color, 16'h0000);
      check_eq("hold_rst_busy", 16'(busy), 16'h0000);
    end
    reset = 1'b0;
    model_reset();
    run(fl * 3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
